regfile_sweep: RTL and testbench

- Parametrised successor to the datapath's fixed 8x16 general-register block.
- Holds NREG general registers and NB temporary (B) latches, all loaded from the shared S-bus by store enables.
- Adds two addressed read ports with same-cycle write bypass.
- Adds a sequenced soft-clear ("sweep") engine that zeroes general registers one per cycle, so the controller can clear the file without asserting CLR.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_sweep_if.sv | 37 +++
 rtl/regfile_sweep_ctl.sv | 94 +++++++++
 rtl/regfile_sweep.sv | 107 ++++++++++
 tb/tb_regfile_sweep.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the general-register file and its sweep controller.
//   - state_t      : sweep FSM states
//   - DEF_WIDTH/DEF_NREG : default data width / register count shared with the datapath top
//   - reg_slice()  : pulls register <idx> of <width> bits out of a flattened bus
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREG  = 8;

  // Upper bounds for the generic slice helper; callers zero-extend into these.
  localparam int unsigned SLICE_MAX_W    = 64;
  localparam int unsigned SLICE_MAX_FLAT = 2048;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  function automatic logic [SLICE_MAX_W-1:0] reg_slice(
    input logic [SLICE_MAX_FLAT-1:0] flat,
    input int unsigned               idx,
    input int unsigned               width
  );
    logic [SLICE_MAX_FLAT-1:0] w_sh;
    w_sh      = flat >> (idx * width);
    reg_slice = '0;
    for (int unsigned k = 0; k < SLICE_MAX_W; k++) begin
      if (k < width) reg_slice[k] = w_sh[k];
    end
  endfunction

endpackage

// File: rtl/regfile_sweep_if.sv
// Bus bundle between the register-file controller (master) and regfile_sweep (slave).
//   master drives : s_bus, sr, sb, rd_addr_a, rd_addr_b, clr_req
//   slave drives  : rd_data_a, rd_data_b, r_q, b_q, busy, done, wr_drop
interface regfile_sweep_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned NB    = 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [WIDTH-1:0]      s_bus;
  logic [NREG-1:0]       sr;
  logic [NB-1:0]         sb;
  logic [AW-1:0]         rd_addr_a;
  logic [AW-1:0]         rd_addr_b;
  logic [WIDTH-1:0]      rd_data_a;
  logic [WIDTH-1:0]      rd_data_b;
  logic [NREG*WIDTH-1:0] r_q;
  logic [NB*WIDTH-1:0]   b_q;
  logic                  clr_req;
  logic                  busy;
  logic                  done;
  logic                  wr_drop;

  modport master (
    output s_bus, sr, sb, rd_addr_a, rd_addr_b, clr_req,
    input  rd_data_a, rd_data_b, r_q, b_q, busy, done, wr_drop
  );

  modport slave (
    input  s_bus, sr, sb, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, r_q, b_q, busy, done, wr_drop
  );

endinterface

// File: rtl/regfile_sweep_ctl.sv
// Soft-clear sequencer: walks idx over the general registers, one clear per cycle.
//   CLK, CLR       : clock, async active-low reset
//   i_clr_req      : sweep request (level, ignored while sweeping)
//   i_sr           : general-register store enables (for drop detection)
//   o_idle/o_busy  : FSM in IDLE / SWEEP
//   o_done         : one-cycle pulse after the final clear edge
//   o_wr_drop      : pulse: a store was discarded in the previous cycle
//   o_clr_mask     : register being cleared at the coming edge
//   o_allow_mask   : registers whose stores are honoured at the coming edge
module regfile_sweep_ctl
  import regfile_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            i_clr_req,
  input  logic [NREG-1:0] i_sr,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_wr_drop,
  output logic [NREG-1:0] o_clr_mask,
  output logic [NREG-1:0] o_allow_mask
);
  localparam int unsigned   AW   = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic          r_done, w_done_nxt;
  logic          r_wr_drop, w_drop_nxt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_done    <= w_done_nxt;
      r_wr_drop <= w_drop_nxt;
    end
  end

  // Exit is decided on the current idx before incrementing, so idx never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        if (r_idx == LAST) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Registers below idx are already cleared and may be written again;
  // idx and above would be (or are being) wiped, so their stores are dropped.
  always_comb begin
    o_clr_mask   = '0;
    o_allow_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      o_clr_mask[i]   = (r_state == ST_SWEEP) && (r_idx == AW'(i));
      o_allow_mask[i] = (r_state == ST_IDLE) || (AW'(i) < r_idx);
    end
  end

  assign w_drop_nxt = |(i_sr & ~o_allow_mask);

  assign o_idle    = (r_state == ST_IDLE);
  assign o_busy    = (r_state == ST_SWEEP);
  assign o_done    = r_done;
  assign o_wr_drop = r_wr_drop;

endmodule

// File: rtl/regfile_sweep.sv
// Parametrised general-register file with B latches, two bypassed read ports
// and a soft-clear sweep engine.
//   CLK, CLR : clock (rising edge), async active-low reset
//   rf       : regfile_sweep_if.slave -- s_bus/sr/sb stores, rd_addr_a/b -> rd_data_a/b,
//              r_q/b_q flattened contents, clr_req/busy/done sweep control, wr_drop
// NREG must be >= 2 and NB >= 1.
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NREG   = DEF_NREG,
  parameter int unsigned NB     = 1,
  parameter bit          BYPASS = 1'b1
) (
  input  logic           CLK,
  input  logic           CLR,
  regfile_sweep_if.slave rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [WIDTH-1:0]      r_reg [NREG];
  logic [WIDTH-1:0]      r_b   [NB];
  logic                  w_idle;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_wr_drop;
  logic [NREG-1:0]       w_clr_mask;
  logic [NREG-1:0]       w_allow_mask;
  logic [AW-1:0]         w_addr [2];
  logic [WIDTH-1:0]      w_rd   [2];
  logic [NREG*WIDTH-1:0] w_rq;
  logic [NB*WIDTH-1:0]   w_bq;

  regfile_sweep_ctl #(
    .NREG(NREG)
  ) u_ctl (
    .CLK         (CLK),
    .CLR         (CLR),
    .i_clr_req   (rf.clr_req),
    .i_sr        (rf.sr),
    .o_idle      (w_idle),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_wr_drop   (w_wr_drop),
    .o_clr_mask  (w_clr_mask),
    .o_allow_mask(w_allow_mask)
  );

  // Sweep clear wins over a store to the same register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int unsigned i = 0; i < NREG; i++) r_reg[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_clr_mask[i])                     r_reg[i] <= '0;
        else if (rf.sr[i] && w_allow_mask[i])  r_reg[i] <= rf.s_bus;
      end
    end
  end

  // B latches are outside the sweep and always accept stores.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int unsigned j = 0; j < NB; j++) r_b[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < NB; j++) begin
        if (rf.sb[j]) r_b[j] <= rf.s_bus;
      end
    end
  end

  assign w_addr[0] = rf.rd_addr_a;
  assign w_addr[1] = rf.rd_addr_b;

  // Address match loop rather than direct indexing keeps out-of-range
  // addresses (non-power-of-2 NREG) reading as zero.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_addr[p] == AW'(i)) begin
          if (BYPASS && w_idle && rf.sr[i]) w_rd[p] = rf.s_bus;
          else                              w_rd[p] = r_reg[i];
        end
      end
    end
  end

  always_comb begin
    w_rq = '0;
    for (int unsigned i = 0; i < NREG; i++) w_rq[i*WIDTH +: WIDTH] = r_reg[i];
  end

  always_comb begin
    w_bq = '0;
    for (int unsigned j = 0; j < NB; j++) w_bq[j*WIDTH +: WIDTH] = r_b[j];
  end

  assign rf.rd_data_a = w_rd[0];
  assign rf.rd_data_b = w_rd[1];
  assign rf.r_q       = w_rq;
  assign rf.b_q       = w_bq;
  assign rf.busy      = w_busy;
  assign rf.done      = w_done;
  assign rf.wr_drop   = w_wr_drop;

endmodule

// File: tb/tb_regfile_sweep.sv
// Scoreboard bench for regfile_sweep: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_regfile_sweep;
  import regfile_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned N   = 8;
  localparam int unsigned NBL = 2;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  regfile_sweep_if #(.WIDTH(W), .NREG(N), .NB(NBL)) rf ();

  regfile_sweep #(
    .WIDTH (W),
    .NREG  (N),
    .NB    (NBL),
    .BYPASS(1'b1)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .rf (rf)
  );

  typedef struct {
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;
    logic [N*W-1:0]   rq;
    logic [NBL*W-1:0] bq;
    logic             busy;
    logic             done;
    logic             drop;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Behavioural model: register contents plus "sweep in progress, next to clear".
  logic [W-1:0] m_reg [N];
  logic [W-1:0] m_b   [NBL];
  bit           m_sweeping;
  int unsigned  m_pos;
  bit           m_done;
  bit           m_drop;

  task automatic check(input string name, input int c, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = '0;
    for (int j = 0; j < NBL; j++) m_b[j] = '0;
    m_sweeping = 0;
    m_pos      = 0;
    m_done     = 0;
    m_drop     = 0;
  endtask

  // Apply one rising edge to the model using the inputs that were held before it.
  task automatic model_edge();
    logic [W-1:0] s;
    s      = rf.s_bus;
    m_done = 0;
    m_drop = 0;
    for (int j = 0; j < NBL; j++) if (rf.sb[j]) m_b[j] = s;
    if (!m_sweeping) begin
      for (int i = 0; i < N; i++) if (rf.sr[i]) m_reg[i] = s;
      if (rf.clr_req) begin
        m_sweeping = 1;
        m_pos      = 0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (rf.sr[i]) begin
          if (i < m_pos) m_reg[i] = s;
          else           m_drop = 1;
        end
      end
      m_reg[m_pos] = '0;
      if (m_pos == N - 1) begin
        m_sweeping = 0;
        m_done     = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [2:0] addr);
    if (!m_sweeping && rf.sr[addr]) return rf.s_bus;
    return m_reg[addr];
  endfunction

  task automatic push_expect();
    exp_t e;
    e.ra = exp_read(rf.rd_addr_a);
    e.rb = exp_read(rf.rd_addr_b);
    for (int i = 0; i < N; i++) e.rq[i*W +: W] = m_reg[i];
    for (int j = 0; j < NBL; j++) e.bq[j*W +: W] = m_b[j];
    e.busy = m_sweeping;
    e.done = m_done;
    e.drop = m_drop;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic drive(input logic [W-1:0] s, input logic [N-1:0] sr, input logic [NBL-1:0] sb,
                       input logic [2:0] a, input logic [2:0] b, input bit clr);
    rf.s_bus     = s;
    rf.sr        = sr;
    rf.sb        = sb;
    rf.rd_addr_a = a;
    rf.rd_addr_b = b;
    rf.clr_req   = clr;
  endtask

  task automatic step(input logic [W-1:0] s, input logic [N-1:0] sr, input logic [NBL-1:0] sb,
                      input logic [2:0] a, input logic [2:0] b, input bit clr);
    @(posedge CLK);
    #1;
    cyc++;
    model_edge();
    drive(s, sr, sb, a, b, clr);
    push_expect();
  endtask

  // Asynchronous reset pulse inside one cycle; outputs must clear without a clock edge.
  task automatic clr_pulse_step();
    @(posedge CLK);
    #1;
    cyc++;
    model_edge();
    drive(W'($urandom), '0, '0, 3'($urandom), 3'($urandom), 1'b0);
    CLR = 1'b0;
    #1;
    check("async_rq",   cyc, 128'(rf.r_q),    128'(0));
    check("async_bq",   cyc, 128'(rf.b_q),    128'(0));
    check("async_busy", cyc, 128'(rf.busy),   128'(0));
    check("async_done", cyc, 128'(rf.done),   128'(0));
    check("async_drop", cyc, 128'(rf.wr_drop), 128'(0));
    model_reset();
    CLR = 1'b1;
    push_expect();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_data_a", e.cyc, 128'(rf.rd_data_a), 128'(e.ra));
        check("rd_data_b", e.cyc, 128'(rf.rd_data_b), 128'(e.rb));
        check("r_q",       e.cyc, 128'(rf.r_q),       128'(e.rq));
        check("b_q",       e.cyc, 128'(rf.b_q),       128'(e.bq));
        check("busy",      e.cyc, 128'(rf.busy),      128'(e.busy));
        check("done",      e.cyc, 128'(rf.done),      128'(e.done));
        check("wr_drop",   e.cyc, 128'(rf.wr_drop),   128'(e.drop));
      end
    end
  end

  initial begin : stim
    drive('0, '0, '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_rq",   cyc, 128'(rf.r_q),  128'(0));
    check("reset_busy", cyc, 128'(rf.busy), 128'(0));
    CLR = 1'b1;
    push_expect();
    step('0, '0, '0, 3'd0, 3'd0, 1'b0);

    // Same-cycle bypass, then the stored values.
    step(16'h1234, 8'b0000_0101, '0, 3'd2, 3'd1, 1'b0);
    step(16'h0000, '0, '0, 3'd0, 3'd2, 1'b0);

    // Load all registers and one B latch, then sweep with a mid-sweep store.
    for (int i = 0; i < N; i++)
      step(W'(16'h1110 + i), N'(1 << i), (i == 0) ? 2'b01 : 2'b00, 3'(i), 3'((i + 7) % N), 1'b0);
    step('0, '0, '0, 3'd0, 3'd7, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) step(16'hBEEF, 8'b1000_0010, '0, 3'd1, 3'd7, 1'b0);
      else        step('0, '0, '0, 3'(k % N), 3'((k + 1) % N), 1'b0);
    end

    // Reload, start a sweep and abort it with CLR at idx=4.
    for (int i = 0; i < N; i++)
      step(W'(16'hA000 + i), N'(1 << i), 2'b10, 3'(i), 3'(N - 1 - i), 1'b0);
    step('0, '0, '0, 3'd3, 3'd5, 1'b1);
    for (int k = 0; k < 4; k++) step('0, '0, '0, 3'(k), 3'(k + 4), 1'b0);
    clr_pulse_step();
    step(16'h5A5A, 8'b0001_1000, '0, 3'd3, 3'd4, 1'b0);
    step('0, '0, '0, 3'd3, 3'd4, 1'b1);
    for (int k = 0; k < 10; k++) step(W'($urandom), '0, '0, 3'(k), 3'd4, 1'b0);

    // clr_req held: back-to-back sweeps with random traffic.
    for (int k = 0; k < 24; k++)
      step(W'($urandom), N'($urandom), NBL'($urandom), 3'($urandom), 3'($urandom), 1'b1);

    // Random traffic with occasional sweeps and async resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) clr_pulse_step();
      else step(W'($urandom), ($urandom_range(0, 2) == 0) ? '0 : N'($urandom), NBL'($urandom),
                3'($urandom), 3'($urandom), $urandom_range(0, 9) == 0);
    end

    @(negedge CLK);
    #1;
    check("queue_drained", cyc, 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
